// File: rtl/addressable_latch_8_pkg.sv
// Shared encodings for the addressable latch: {clr,we} modes, FSM states, last scan index.
package addressable_latch_8_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD  = 2'b00;
    localparam mode_t MODE_WRITE = 2'b01;
    localparam mode_t MODE_CLEAR = 2'b10;
    localparam mode_t MODE_DEMUX = 2'b11;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    localparam logic [2:0] LAST_INDEX = 3'd7;

endpackage

// File: rtl/addressable_latch_8_decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder used to pick the latch bit being written.
module decoder_3to8 (
    input  logic [2:0] i_index,
    output logic [7:0] o_mask
);

    assign o_mask = 8'b0000_0001 << i_index;

endmodule

// File: rtl/addressable_latch_8.sv
// Clocked 8-bit addressable latch with write/hold/demux/clear modes and an 8-bit serial scan.
module addressable_latch_8
    import addressable_latch_8_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dataIn,
    input  logic [2:0] sel,
    input  logic       we,
    input  logic       clr,
    input  logic       start,
    output logic [7:0] latchOut,
    output logic       busy,
    output logic [2:0] scanPtr,
    output logic       frameDone
);

    logic       r_state;
    logic [7:0] r_latch;
    logic [2:0] r_ptr;
    logic       r_frameDone;

    logic [2:0] w_index;
    logic [7:0] w_mask;
    logic [7:0] w_data;
    logic [7:0] w_merged;
    mode_t      w_mode;

    // One decoder serves both the addressed write and the scan write.
    assign w_index  = (r_state == ST_SCAN) ? r_ptr : sel;
    assign w_data   = {8{dataIn}};
    assign w_merged = (r_latch & ~w_mask) | (w_data & w_mask);
    assign w_mode   = {clr, we};

    decoder_3to8 u_decoder (
        .i_index (w_index),
        .o_mask  (w_mask)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_latch     <= RESET_VALUE;
            r_ptr       <= 3'd0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (r_state == ST_IDLE) begin
                // clr takes precedence over start; start wins over a plain write.
                if (clr) begin
                    r_latch <= (w_mode == MODE_DEMUX) ? (w_data & w_mask) : 8'h00;
                end else if (start) begin
                    r_state <= ST_SCAN;
                    r_ptr   <= 3'd0;
                end else if (w_mode == MODE_WRITE) begin
                    r_latch <= w_merged;
                end
            end else begin
                if (clr) begin
                    r_latch <= 8'h00;
                    r_state <= ST_IDLE;
                    r_ptr   <= 3'd0;
                end else begin
                    r_latch <= w_merged;
                    if (r_ptr == LAST_INDEX) begin
                        r_state     <= ST_IDLE;
                        r_ptr       <= 3'd0;
                        r_frameDone <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 3'd1;
                    end
                end
            end
        end
    end

    assign latchOut  = r_latch;
    assign busy      = (r_state == ST_SCAN);
    assign scanPtr   = r_ptr;
    assign frameDone = r_frameDone;

endmodule

// File: tb/tb_addressable_latch_8.sv
// Self-checking bench: directed vector table, hand-written scan corner cases, then random vs a model.
module tb_addressable_latch_8;

    localparam logic [7:0] RV = 8'hA5;

    logic       clock = 1'b0;
    logic       reset;
    logic       dataIn;
    logic [2:0] sel;
    logic       we;
    logic       clr;
    logic       start;
    logic [7:0] latchOut;
    logic       busy;
    logic [2:0] scanPtr;
    logic       frameDone;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       rst;
        logic       d;
        logic [2:0] s;
        logic       w;
        logic       c;
        logic       st;
        logic [7:0] expLatch;
        logic       expBusy;
        logic [2:0] expPtr;
        logic       expDone;
    } vec_t;

    vec_t vecs[$];

    addressable_latch_8 #(.RESET_VALUE(RV)) dut (
        .clock     (clock),
        .reset     (reset),
        .dataIn    (dataIn),
        .sel       (sel),
        .we        (we),
        .clr       (clr),
        .start     (start),
        .latchOut  (latchOut),
        .busy      (busy),
        .scanPtr   (scanPtr),
        .frameDone (frameDone)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Drive one cycle of inputs, take the edge, and leave time for outputs to settle.
    task automatic applyStimulus(input logic rst, input logic d, input logic [2:0] s,
                                 input logic w, input logic c, input logic st);
        reset  = rst;
        dataIn = d;
        sel    = s;
        we     = w;
        clr    = c;
        start  = st;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expLatch,
                               input logic expBusy, input logic [2:0] expPtr, input logic expDone);
        testsRun++;
        if (latchOut !== expLatch || busy !== expBusy || scanPtr !== expPtr || frameDone !== expDone) begin
            testsFailed++;
            $display("[TB] FAIL %s: got latch=%h busy=%b ptr=%0d done=%b, expected latch=%h busy=%b ptr=%0d done=%b",
                     name, latchOut, busy, scanPtr, frameDone, expLatch, expBusy, expPtr, expDone);
        end
    endtask

    task automatic addVec(input logic rst, input logic d, input logic [2:0] s, input logic w,
                          input logic c, input logic st, input logic [7:0] el,
                          input logic eb, input logic [2:0] ep, input logic ed);
        vec_t v;
        v.rst = rst; v.d = d; v.s = s; v.w = w; v.c = c; v.st = st;
        v.expLatch = el; v.expBusy = eb; v.expPtr = ep; v.expDone = ed;
        vecs.push_back(v);
    endtask

    // Reference model state: bit array plus a count of bits captured in the current scan.
    logic [7:0] mLatch;
    bit         mScanning;
    int         mCount;
    bit         mDone;

    task automatic modelStep(input logic rst, input logic d, input logic [2:0] s,
                             input logic w, input logic c, input logic st);
        mDone = 0;
        if (rst) begin
            mLatch = RV; mScanning = 0; mCount = 0;
        end else if (!mScanning) begin
            if (c) begin
                mLatch = 8'h00;
                if (w) mLatch[s] = d;
            end else if (st) begin
                mScanning = 1; mCount = 0;
            end else if (w) begin
                mLatch[s] = d;
            end
        end else if (c) begin
            mLatch = 8'h00; mScanning = 0; mCount = 0;
        end else begin
            mLatch[mCount] = d;
            mCount++;
            if (mCount == 8) begin
                mScanning = 0; mCount = 0; mDone = 1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; dataIn = 0; sel = 0; we = 0; clr = 0; start = 0;

        // Reset and hold
        addVec(1,0,0,0,0,0, 8'hA5,0,0,0);
        addVec(0,0,0,0,0,0, 8'hA5,0,0,0);
        addVec(0,1,3,0,0,0, 8'hA5,0,0,0);
        addVec(0,0,7,0,0,0, 8'hA5,0,0,0);
        // Clear then writes
        addVec(0,0,0,0,1,0, 8'h00,0,0,0);
        addVec(0,1,3,1,0,0, 8'h08,0,0,0);
        addVec(0,1,6,1,0,0, 8'h48,0,0,0);
        addVec(0,0,3,1,0,0, 8'h40,0,0,0);
        // All-ones scan to reach FF
        addVec(0,0,0,0,0,1, 8'h40,1,0,0);
        addVec(0,1,0,0,0,0, 8'h41,1,1,0);
        addVec(0,1,0,0,0,0, 8'h43,1,2,0);
        addVec(0,1,0,0,0,0, 8'h47,1,3,0);
        addVec(0,1,0,0,0,0, 8'h4F,1,4,0);
        addVec(0,1,0,0,0,0, 8'h5F,1,5,0);
        addVec(0,1,0,0,0,0, 8'h7F,1,6,0);
        addVec(0,1,0,0,0,0, 8'h7F,1,7,0);
        addVec(0,1,0,0,0,0, 8'hFF,0,0,1);
        addVec(0,0,0,0,0,0, 8'hFF,0,0,0);
        // Demux then clear
        addVec(0,1,5,1,1,0, 8'h20,0,0,0);
        addVec(0,0,0,0,1,0, 8'h00,0,0,0);
        // start with clr in IDLE executes demux, ignores start
        addVec(0,1,4,1,1,1, 8'h10,0,0,0);
        addVec(0,0,0,0,1,0, 8'h00,0,0,0);
        // Scan 1,0,1,1,0,0,1,0 with a stray write mid-scan
        addVec(0,0,0,0,0,1, 8'h00,1,0,0);
        addVec(0,1,0,0,0,0, 8'h01,1,1,0);
        addVec(0,0,0,0,0,0, 8'h01,1,2,0);
        addVec(0,1,0,0,0,0, 8'h05,1,3,0);
        addVec(0,1,0,0,0,0, 8'h0D,1,4,0);
        addVec(0,0,0,1,0,1, 8'h0D,1,5,0);
        addVec(0,0,0,0,0,0, 8'h0D,1,6,0);
        addVec(0,1,0,0,0,0, 8'h4D,1,7,0);
        addVec(0,0,0,0,0,0, 8'h4D,0,0,1);
        addVec(0,0,0,0,0,0, 8'h4D,0,0,0);
        // start with we in IDLE: write ignored; abort at E4
        addVec(0,0,0,1,0,1, 8'h4D,1,0,0);
        addVec(0,1,0,0,0,0, 8'h4D,1,1,0);
        addVec(0,1,0,0,0,0, 8'h4F,1,2,0);
        addVec(0,1,0,0,0,0, 8'h4F,1,3,0);
        addVec(0,1,0,0,1,0, 8'h00,0,0,0);
        addVec(0,0,0,0,0,0, 8'h00,0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].d, vecs[i].s, vecs[i].w, vecs[i].c, vecs[i].st);
            checkOutput($sformatf("vec%0d", i), vecs[i].expLatch, vecs[i].expBusy,
                        vecs[i].expPtr, vecs[i].expDone);
        end

        // Reset asserted at E5 of a scan
        applyStimulus(0,0,0,0,0,1);
        for (int k = 0; k < 4; k++) applyStimulus(0,1,0,0,0,0);
        checkOutput("preResetScan", 8'h0F, 1, 4, 0);
        applyStimulus(1,1,0,0,0,0);
        checkOutput("resetMidScan", RV, 0, 0, 0);
        applyStimulus(0,0,0,0,0,0);
        checkOutput("afterResetNoDone", RV, 0, 0, 0);

        // Back-to-back frames: start accepted during the frameDone cycle
        applyStimulus(0,0,0,0,0,1);
        for (int k = 0; k < 8; k++) applyStimulus(0,(k % 2 == 0),0,0,0,0);
        checkOutput("frame1Done", 8'h55, 0, 0, 1);
        applyStimulus(0,0,0,0,0,1);
        checkOutput("frame2Start", 8'h55, 1, 0, 0);
        applyStimulus(0,0,0,0,0,0);
        checkOutput("frame2Bit0", 8'h54, 1, 1, 0);

        // Randomized run against the reference model
        applyStimulus(1,0,0,0,0,0);
        modelStep(1,0,0,0,0,0);
        for (int n = 0; n < 600; n++) begin
            logic       r, d, w, c, st;
            logic [2:0] s;
            r  = ($urandom_range(0, 40) == 0);
            d  = $urandom_range(0, 1);
            s  = 3'($urandom_range(0, 7));
            w  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 5) == 0);
            applyStimulus(r, d, s, w, c, st);
            modelStep(r, d, s, w, c, st);
            checkOutput($sformatf("rand%0d", n), mLatch, mScanning,
                        mScanning ? 3'(mCount) : 3'd0, mDone);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
